// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: operation codes,
// FSM state encoding, operation classification helpers and the mapping
// from the instruction decoder's alucontrol field onto unit operations.
package mul_div_unit_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Decoder alucontrol codes that target the multiply-divide unit.
  localparam logic [3:0] ALUC_MULT  = 4'b1000;
  localparam logic [3:0] ALUC_MULTU = 4'b1001;
  localparam logic [3:0] ALUC_DIV   = 4'b1010;
  localparam logic [3:0] ALUC_DIVU  = 4'b1011;
  localparam logic [3:0] ALUC_MTHI  = 4'b1100;
  localparam logic [3:0] ALUC_MTLO  = 4'b1101;

  typedef struct packed {
    logic    valid;  // alucontrol addresses the unit
    mdu_op_e op;
  } mdu_req_t;

  // Translate a decoder alucontrol code into a unit request.
  function automatic mdu_req_t aluc_to_mdu(input logic [3:0] aluc);
    mdu_req_t req;
    req.valid = 1'b1;
    req.op    = OP_MULT;
    case (aluc)
      ALUC_MULT:  req.op = OP_MULT;
      ALUC_MULTU: req.op = OP_MULTU;
      ALUC_DIV:   req.op = OP_DIV;
      ALUC_DIVU:  req.op = OP_DIVU;
      ALUC_MTHI:  req.op = OP_MTHI;
      ALUC_MTLO:  req.op = OP_MTLO;
      default:    req.valid = 1'b0;
    endcase
    return req;
  endfunction

  // Multi-cycle arithmetic operations (codes 0..3).
  function automatic logic op_is_arith(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply-divide unit.
// Handshake: a request is taken on a rising clock edge when start_i=1,
// ready_o=1 and cancel_i=0; start_i at any other time is dropped, never
// queued. done_o pulses for one cycle when an arithmetic result lands in
// HI/LO; busy_o (= ~ready_o) is the pipeline stall request.
interface mul_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic              cancel_i;
  logic              ready_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, cancel_i,
    input  ready_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, cancel_i,
    output ready_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit_div_step.sv
// One iteration of unsigned restoring division. The partial remainder is
// shifted left taking the next dividend bit from the top of the quotient
// register; if the divisor fits it is subtracted and a 1 enters the
// quotient, otherwise the shifted remainder is kept and a 0 enters.
module mdu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtract; bit DATA_W of diff is the borrow (divisor did not fit).
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, div_i};
    rem_o   = diff[DATA_W-1:0];
    quo_o   = {quo_i[DATA_W-2:0], 1'b1};
    if (diff[DATA_W]) begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply-divide unit. Arithmetic runs on operand
// magnitudes for DATA_W cycles (shift-add multiply, restoring divide),
// then a FIX cycle applies the result signs and writes HI/LO. MTHI/MTLO
// write HI/LO directly on the accepting edge without leaving IDLE.
// DATA_W must be even and within 8..64.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  mul_div_unit_if.slave mdu,
  output mdu_state_e    state_dbg
);
  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;

  // Working registers: acc_q is the upper product half / partial
  // remainder, shr_q the multiplier-then-low-product / dividend-then-
  // quotient, opnd_q the multiplicand / divisor magnitude.
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   shr_q;
  logic [DATA_W-1:0]   opnd_q;
  logic                is_div_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic                divz_q;

  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                done_q;

  logic                accept;
  logic                accept_calc;
  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   div_rem;
  logic [DATA_W-1:0]   div_quo;

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Request acceptance and operand magnitude extraction.
  always_comb begin
    accept      = mdu.start_i && (state_q == ST_IDLE) && !mdu.cancel_i;
    accept_calc = accept && op_is_arith(mdu.op_i);
    op_signed   = op_is_signed(mdu.op_i);
    a_neg       = op_signed && mdu.a_i[DATA_W-1];
    b_neg       = op_signed && mdu.b_i[DATA_W-1];
    a_mag       = a_neg ? -mdu.a_i : mdu.a_i;
    b_mag       = b_neg ? -mdu.b_i : mdu.b_i;
  end

  // Multiply iteration: conditionally add the multiplicand into the upper
  // half, then shift the whole product right one place.
  always_comb begin
    mul_sum = {1'b0, acc_q};
    if (shr_q[0]) begin
      mul_sum = {1'b0, acc_q} + {1'b0, opnd_q};
    end
  end

  mdu_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_i (acc_q),
    .quo_i (shr_q),
    .div_i (opnd_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Sign correction applied in FIX; a zero divisor forces an all-ones
  // quotient while the remainder path naturally returns the dividend.
  always_comb begin
    prod     = {acc_q, shr_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -shr_q : shr_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
    if (divz_q) begin
      quo_fix = '1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> CALC on an arithmetic accept, CALC -> FIX after
  // the last iteration, FIX -> IDLE; cancel aborts CALC/FIX.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_calc) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mdu.cancel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand latch on accept and one datapath iteration per CALC cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      shr_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
      if (accept_calc) begin
        acc_q     <= '0;
        is_div_q  <= op_is_div(mdu.op_i);
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        divz_q    <= (mdu.b_i == '0);
        if (op_is_div(mdu.op_i)) begin
          shr_q  <= a_mag;
          opnd_q <= b_mag;
        end else begin
          shr_q  <= b_mag;
          opnd_q <= a_mag;
        end
      end
    end else if (state_q == ST_CALC) begin
      if (mdu.cancel_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
        if (is_div_q) begin
          acc_q <= div_rem;
          shr_q <= div_quo;
        end else begin
          acc_q <= mul_sum[DATA_W:1];
          shr_q <= {mul_sum[0], shr_q[DATA_W-1:1]};
        end
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Architectural HI/LO: direct moves on accept, arithmetic results in FIX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && (mdu.op_i == OP_MTHI)) begin
        hi_q <= mdu.a_i;
      end
      if (accept && (mdu.op_i == OP_MTLO)) begin
        lo_q <= mdu.a_i;
      end
      if ((state_q == ST_FIX) && !mdu.cancel_i) begin
        done_q <= 1'b1;
        if (is_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[2*DATA_W-1:DATA_W];
          lo_q <= prod_fix[DATA_W-1:0];
        end
      end
    end
  end

  assign mdu.ready_o = (state_q == ST_IDLE);
  assign mdu.busy_o  = (state_q != ST_IDLE);
  assign mdu.done_o  = done_q;
  assign mdu.hi_o    = hi_q;
  assign mdu.lo_o    = lo_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a 32-bit and a 16-bit instance share clock and
// reset. Results are predicted by a plain-arithmetic model of HI/LO.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic       clk;
  logic       resetn;
  mdu_state_e state_dbg32;
  mdu_state_e state_dbg16;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  logic [63:0]  m_hi[2];
  logic [63:0]  m_lo[2];

  mul_div_unit_if #(.DATA_W(32)) bus32 ();
  mul_div_unit_if #(.DATA_W(16)) bus16 ();

  mul_div_unit #(.DATA_W(32)) dut32 (
    .clk       (clk),
    .resetn    (resetn),
    .mdu       (bus32.slave),
    .state_dbg (state_dbg32)
  );

  mul_div_unit #(.DATA_W(16)) dut16 (
    .clk       (clk),
    .resetn    (resetn),
    .mdu       (bus16.slave),
    .state_dbg (state_dbg16)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit, got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {hi, lo} (64 bits each, masked to w) after one operation.
  function automatic logic [127:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] hi_in, input logic [63:0] lo_in);
    logic [63:0] mask;
    logic [63:0] ua, ub, hi, lo, p;
    longint      sa, sb, sp, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = longint'(ua << (64 - w));
    sa = sa >>> (64 - w);
    sb = longint'(ub << (64 - w));
    sb = sb >>> (64 - w);
    hi = hi_in;
    lo = lo_in;
    case (op)
      3'd0: begin sp = sa * sb; p = 64'(sp); hi = (p >> w) & mask; lo = p & mask; end
      3'd1: begin p = ua * ub; hi = (p >> w) & mask; lo = p & mask; end
      3'd2: begin
        if (sb == 0) begin lo = mask; hi = ua; end
        else begin q = sa / sb; r = sa % sb; lo = 64'(q) & mask; hi = 64'(r) & mask; end
      end
      3'd3: begin
        if (ub == 0) begin lo = mask; hi = ua; end
        else begin lo = ua / ub; hi = ua % ub; end
      end
      3'd4: hi = ua;
      3'd5: lo = ua;
      default: ;
    endcase
    return {hi, lo};
  endfunction

  // ---------------- bus access ----------------
  task automatic drive(input int w, input logic s, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic c);
    if (w == 16) begin
      bus16.start_i = s; bus16.op_i = op; bus16.a_i = a[15:0]; bus16.b_i = b[15:0]; bus16.cancel_i = c;
    end else begin
      bus32.start_i = s; bus32.op_i = op; bus32.a_i = a[31:0]; bus32.b_i = b[31:0]; bus32.cancel_i = c;
    end
  endtask

  function automatic logic [63:0] rd_hi(input int w);
    if (w == 16) return {48'd0, bus16.hi_o};
    return {32'd0, bus32.hi_o};
  endfunction

  function automatic logic [63:0] rd_lo(input int w);
    if (w == 16) return {48'd0, bus16.lo_o};
    return {32'd0, bus32.lo_o};
  endfunction

  function automatic logic [63:0] rd_flags(input int w);
    // {ready, busy, done}
    if (w == 16) return {61'd0, bus16.ready_o, bus16.busy_o, bus16.done_o};
    return {61'd0, bus32.ready_o, bus32.busy_o, bus32.done_o};
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Arithmetic op: accept, keep junk on the inputs (plus ignored start
  // requests) while busy, then check latency, result and done pulse.
  task automatic run_arith(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int           k;
    int           lat;
    logic         got_done;
    logic [127:0] e;
    logic [63:0]  hi0, lo0;
    k = (w == 16) ? 1 : 0;
    exp_q.push_back(ref_model(w, op, a, b, m_hi[k], m_lo[k]));
    hi0 = rd_hi(w);
    lo0 = rd_lo(w);
    check("ready_before_op", rd_flags(w), 64'b100);
    drive(w, 1'b1, op, a, b, 1'b0);
    @(posedge clk); #1;
    check("busy_after_accept", rd_flags(w), 64'b010);
    lat = 0;
    got_done = 1'b0;
    while (lat < 200 && !got_done) begin
      drive(w, lat < 4, OP_MTHI, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      @(posedge clk); #1;
      lat++;
      got_done = rd_flags(w)[0];
      if (lat == w / 2) begin
        check("hi_hold_busy", rd_hi(w), hi0);
        check("lo_hold_busy", rd_lo(w), lo0);
      end
    end
    check("latency", 64'(lat), 64'(w + 1));
    e = exp_q.pop_front();
    check("result_hi", rd_hi(w), e[127:64]);
    check("result_lo", rd_lo(w), e[63:0]);
    check("flags_at_done", rd_flags(w), 64'b101);
    m_hi[k] = e[127:64];
    m_lo[k] = e[63:0];
    drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", rd_flags(w), 64'b100);
  endtask

  // MTHI/MTLO: one accepting edge, no busy, no done. Leaves start low so
  // two calls in a row are back-to-back requests.
  task automatic run_move(input int w, input logic [2:0] op, input logic [63:0] a);
    int           k;
    logic [127:0] e;
    k = (w == 16) ? 1 : 0;
    e = ref_model(w, op, a, {$urandom, $urandom}, m_hi[k], m_lo[k]);
    drive(w, 1'b1, op, a, {$urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("move_hi", rd_hi(w), e[127:64]);
    check("move_lo", rd_lo(w), e[63:0]);
    check("move_flags", rd_flags(w), 64'b100);
    m_hi[k] = e[127:64];
    m_lo[k] = e[63:0];
  endtask

  // Start MULTU, raise cancel so that edge N+at_iter aborts it.
  task automatic run_cancel(input int w, input int at_iter);
    int          k;
    logic        seen;
    k = (w == 16) ? 1 : 0;
    drive(w, 1'b1, OP_MULTU, pick(w) | 64'd3, pick(w) | 64'd5, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (at_iter - 1) @(posedge clk);
    #1;
    drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("cancel_ready", rd_flags(w), 64'b100);
    seen = 1'b0;
    repeat (w + 4) begin
      @(posedge clk); #1;
      if (rd_flags(w)[0]) seen = 1'b1;
    end
    check("cancel_no_done", 64'(seen), 64'd0);
    check("cancel_hi_kept", rd_hi(w), m_hi[k]);
    check("cancel_lo_kept", rd_lo(w), m_lo[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  rop;
    logic        seen;
    resetn = 1'b0;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    drive(16, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin m_hi[i] = 64'd0; m_lo[i] = 64'd0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", rd_hi(32), 64'd0);
    check("reset_lo", rd_lo(32), 64'd0);
    check("reset_flags", rd_flags(32), 64'b100);
    check("reset_state", 64'(state_dbg32), 64'(ST_IDLE));
    check("reset_flags16", rd_flags(16), 64'b100);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases.
    run_arith(32, OP_MULT, 64'hFFFF_FFFE, 64'h3);
    run_arith(32, OP_DIVU, 64'd100, 64'd7);
    run_arith(32, OP_DIV, 64'hFFFF_FFF9, 64'd2);
    run_arith(32, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF);
    run_arith(32, OP_DIVU, 64'd5, 64'd0);
    run_arith(32, OP_DIV, 64'hFFFF_FF00, 64'd0);
    run_arith(32, OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);

    // Back-to-back moves.
    run_move(32, OP_MTHI, 64'h1234_5678);
    run_move(32, OP_MTLO, 64'h9ABC_DEF0);

    // Cancel mid-CALC and in FIX.
    run_cancel(32, 10);
    run_cancel(32, 33);

    // Cancel together with start: nothing happens.
    drive(32, 1'b1, OP_MTHI, 64'hDEAD_BEEF, 64'd0, 1'b1);
    @(posedge clk); #1;
    check("cancel_start_hi", rd_hi(32), m_hi[0]);
    check("cancel_start_flags", rd_flags(32), 64'b100);
    drive(32, 1'b1, OP_DIV, 64'd9, 64'd3, 1'b1);
    @(posedge clk); #1;
    check("cancel_start_idle", rd_flags(32), 64'b100);
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      if (rop >= 3'd4) run_move(32, rop, pick(32));
      else run_arith(32, rop, pick(32), pick(32));
    end

    // Reset in the middle of a DIV.
    drive(32, 1'b1, OP_DIV, 64'h7654_3210, 64'd3, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("midreset_hi", rd_hi(32), 64'd0);
    check("midreset_lo", rd_lo(32), 64'd0);
    check("midreset_flags", rd_flags(32), 64'b100);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin m_hi[i] = 64'd0; m_lo[i] = 64'd0; end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rd_flags(32)[0]) seen = 1'b1;
    end
    check("midreset_no_done", 64'(seen), 64'd0);

    // 16-bit instance.
    run_arith(16, OP_MULTU, 64'hFFFF, 64'hFFFF);
    run_arith(16, OP_DIV, 64'h8000, 64'hFFFF);
    run_arith(16, OP_DIV, 64'hFFF9, 64'd2);
    run_arith(16, OP_DIVU, 64'd5, 64'd0);
    run_arith(16, OP_MULT, 64'h8000, 64'h8000);
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 5));
      if (rop >= 3'd4) run_move(16, rop, pick(16));
      else run_arith(16, rop, pick(16), pick(16));
    end
    run_cancel(16, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
